key_entry_fsm: RTL and testbench

//   Sequential key-entry stage between KeyboardDecoder and the calculator datapath.

---
 rtl/key_entry_if.sv | 22 ++
 rtl/key_entry_fsm.sv | 213 +++++++++++++++++++++
 tb/tb_key_entry_fsm.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_entry_if.sv
// Key-entry bus: decoder-side key events in, calculator-facing operands and display out.
interface key_entry_if;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic [6:0]   operand_a;
  logic [6:0]   operand_b;
  logic [1:0]   opcode;
  logic         calc_go;
  logic [1:0]   entry_state;
  logic [15:0]  disp;

  modport master (
    output key_down, last_change, key_valid,
    input  operand_a, operand_b, opcode, calc_go, entry_state, disp
  );

  modport slave (
    input  key_down, last_change, key_valid,
    output operand_a, operand_b, opcode, calc_go, entry_state, disp
  );
endinterface

// File: rtl/key_entry_fsm.sv
// Key-entry sequencer: collects operand A, operator, operand B and Enter from PS/2 make
// events, keeps operands/opcode/display registered and pulses calc_go on commit.
module key_entry_fsm #(
  parameter bit         KEYPAD_EN  = 1'b1,
  parameter logic [8:0] ENTER_CODE = 9'h05A,
  parameter logic [8:0] ESC_CODE   = 9'h076
) (
  input logic        clk,
  input logic        rst,
  key_entry_if.slave bus
);

  typedef enum logic [1:0] {
    StAEntry = 2'b00,
    StBEntry = 2'b01,
    StResult = 2'b10
  } state_e;

  // {valid, value}; keypad codes only count when KEYPAD_EN is set
  function automatic logic [4:0] decode_digit(input logic [8:0] code);
    logic [4:0] r;
    r = 5'b0;
    case (code)
      9'h045: r = {1'b1, 4'd0};
      9'h016: r = {1'b1, 4'd1};
      9'h01E: r = {1'b1, 4'd2};
      9'h026: r = {1'b1, 4'd3};
      9'h025: r = {1'b1, 4'd4};
      9'h02E: r = {1'b1, 4'd5};
      9'h036: r = {1'b1, 4'd6};
      9'h03D: r = {1'b1, 4'd7};
      9'h03E: r = {1'b1, 4'd8};
      9'h046: r = {1'b1, 4'd9};
      9'h070: r = {KEYPAD_EN, 4'd0};
      9'h069: r = {KEYPAD_EN, 4'd1};
      9'h072: r = {KEYPAD_EN, 4'd2};
      9'h07A: r = {KEYPAD_EN, 4'd3};
      9'h06B: r = {KEYPAD_EN, 4'd4};
      9'h073: r = {KEYPAD_EN, 4'd5};
      9'h074: r = {KEYPAD_EN, 4'd6};
      9'h06C: r = {KEYPAD_EN, 4'd7};
      9'h075: r = {KEYPAD_EN, 4'd8};
      9'h07D: r = {KEYPAD_EN, 4'd9};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

  // {valid, opcode}
  function automatic logic [2:0] decode_op(input logic [8:0] code);
    logic [2:0] r;
    r = 3'b0;
    case (code)
      9'h079: r = {1'b1, 2'b00};
      9'h07B: r = {1'b1, 2'b01};
      9'h07C: r = {1'b1, 2'b10};
      default: r = 3'b0;
    endcase
    return r;
  endfunction

  // Two-digit display field; unused tens (or both digits) shown blank
  function automatic logic [7:0] field(input logic [1:0] cnt, input logic [3:0] hi,
                                       input logic [3:0] lo);
    logic [7:0] r;
    case (cnt)
      2'd0:    r = 8'hFF;
      2'd1:    r = {4'hF, lo};
      default: r = {hi, lo};
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [6:0]  a_q, a_d, b_q, b_d;
  logic [1:0]  a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [3:0]  a_hi_q, a_hi_d, a_lo_q, a_lo_d;
  logic [3:0]  b_hi_q, b_hi_d, b_lo_q, b_lo_d;
  logic [1:0]  opcode_q, opcode_d;
  logic        go_q, go_d;
  logic [15:0] disp_q, disp_d;

  logic       press;
  logic [4:0] dig_dec;
  logic [2:0] op_dec;
  logic       dig_v, op_v;
  logic [3:0] dig;
  logic [1:0] op_val;

  assign press   = bus.key_valid & bus.key_down[bus.last_change];
  assign dig_dec = decode_digit(bus.last_change);
  assign op_dec  = decode_op(bus.last_change);
  assign dig_v   = dig_dec[4];
  assign dig     = dig_dec[3:0];
  assign op_v    = op_dec[2];
  assign op_val  = op_dec[1:0];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    a_cnt_d  = a_cnt_q;
    b_cnt_d  = b_cnt_q;
    a_hi_d   = a_hi_q;
    a_lo_d   = a_lo_q;
    b_hi_d   = b_hi_q;
    b_lo_d   = b_lo_q;
    opcode_d = opcode_q;
    go_d     = 1'b0;

    if (press) begin
      if (bus.last_change == ESC_CODE) begin
        state_d  = StAEntry;
        a_d      = 7'd0;
        b_d      = 7'd0;
        a_cnt_d  = 2'd0;
        b_cnt_d  = 2'd0;
        a_hi_d   = 4'd0;
        a_lo_d   = 4'd0;
        b_hi_d   = 4'd0;
        b_lo_d   = 4'd0;
        opcode_d = 2'b00;
      end else begin
        case (state_q)
          StAEntry: begin
            if (dig_v && a_cnt_q != 2'd2) begin
              a_d     = a_q * 7'd10 + {3'b0, dig};
              a_hi_d  = a_lo_q;
              a_lo_d  = dig;
              a_cnt_d = a_cnt_q + 2'd1;
            end else if (op_v && a_cnt_q != 2'd0) begin
              opcode_d = op_val;
              state_d  = StBEntry;
            end
          end
          StBEntry: begin
            if (dig_v && b_cnt_q != 2'd2) begin
              b_d     = b_q * 7'd10 + {3'b0, dig};
              b_hi_d  = b_lo_q;
              b_lo_d  = dig;
              b_cnt_d = b_cnt_q + 2'd1;
            end else if (op_v && b_cnt_q == 2'd0) begin
              opcode_d = op_val;
            end else if (bus.last_change == ENTER_CODE && b_cnt_q != 2'd0) begin
              state_d = StResult;
              go_d    = 1'b1;
            end
          end
          StResult: begin
            // A new digit starts a fresh expression with that digit as operand A
            if (dig_v) begin
              state_d  = StAEntry;
              a_d      = {3'b0, dig};
              a_hi_d   = 4'd0;
              a_lo_d   = dig;
              a_cnt_d  = 2'd1;
              b_d      = 7'd0;
              b_hi_d   = 4'd0;
              b_lo_d   = 4'd0;
              b_cnt_d  = 2'd0;
              opcode_d = 2'b00;
            end
          end
          default: state_d = StAEntry;
        endcase
      end
    end

    if (state_d == StAEntry) begin
      disp_d = {8'hFF, field(a_cnt_d, a_hi_d, a_lo_d)};
    end else begin
      disp_d = {field(a_cnt_d, a_hi_d, a_lo_d), field(b_cnt_d, b_hi_d, b_lo_d)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StAEntry;
      a_q      <= 7'd0;
      b_q      <= 7'd0;
      a_cnt_q  <= 2'd0;
      b_cnt_q  <= 2'd0;
      a_hi_q   <= 4'd0;
      a_lo_q   <= 4'd0;
      b_hi_q   <= 4'd0;
      b_lo_q   <= 4'd0;
      opcode_q <= 2'b00;
      go_q     <= 1'b0;
      disp_q   <= 16'hFFFF;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_cnt_q  <= a_cnt_d;
      b_cnt_q  <= b_cnt_d;
      a_hi_q   <= a_hi_d;
      a_lo_q   <= a_lo_d;
      b_hi_q   <= b_hi_d;
      b_lo_q   <= b_lo_d;
      opcode_q <= opcode_d;
      go_q     <= go_d;
      disp_q   <= disp_d;
    end
  end

  assign bus.operand_a   = a_q;
  assign bus.operand_b   = b_q;
  assign bus.opcode      = opcode_q;
  assign bus.calc_go     = go_q;
  assign bus.entry_state = state_q;
  assign bus.disp        = disp_q;

endmodule

// File: tb/tb_key_entry_fsm.sv
// Bench for key_entry_fsm: vector table, hand-written corner sequences and random
// key events against an arithmetic reference model; a keypad-disabled copy runs alongside.
module tb_key_entry_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_entry_if bus1();
  key_entry_if bus0();

  assign bus0.key_down    = bus1.key_down;
  assign bus0.last_change = bus1.last_change;
  assign bus0.key_valid   = bus1.key_valid;

  key_entry_fsm #(.KEYPAD_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus1));
  key_entry_fsm #(.KEYPAD_EN(1'b0)) dut_nokp (.clk(clk), .rst(rst), .bus(bus0));

  int total = 0;
  int bad   = 0;

  // Reference model, index 0 = keypad disabled, 1 = keypad enabled
  int ma[2], mb[2], mac[2], mbc[2], mop[2], mst[2], mgo[2];
  int top_codes[10] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};
  int pad_codes[10] = '{'h70, 'h69, 'h72, 'h7A, 'h6B, 'h73, 'h74, 'h6C, 'h75, 'h7D};

  function automatic int digit_of(input logic [8:0] c, input int kp);
    for (int i = 0; i < 10; i++) begin
      if (int'(c) == top_codes[i]) return i;
      if (kp != 0 && int'(c) == pad_codes[i]) return i;
    end
    return -1;
  endfunction

  function automatic int op_of(input logic [8:0] c);
    if (c == 9'h079) return 0;
    if (c == 9'h07B) return 1;
    if (c == 9'h07C) return 2;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ma[k] = 0; mb[k] = 0; mac[k] = 0; mbc[k] = 0; mop[k] = 0; mst[k] = 0; mgo[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic [8:0] c, input bit down, input bit valid);
    int d;
    int o;
    mgo[k] = 0;
    if (!(valid && down)) return;
    d = digit_of(c, k);
    o = op_of(c);
    if (c == 9'h076) begin
      ma[k] = 0; mb[k] = 0; mac[k] = 0; mbc[k] = 0; mop[k] = 0; mst[k] = 0;
    end else if (mst[k] == 0) begin
      if (d >= 0 && mac[k] < 2) begin
        ma[k] = ma[k] * 10 + d; mac[k]++;
      end else if (o >= 0 && mac[k] >= 1) begin
        mop[k] = o; mst[k] = 1;
      end
    end else if (mst[k] == 1) begin
      if (d >= 0 && mbc[k] < 2) begin
        mb[k] = mb[k] * 10 + d; mbc[k]++;
      end else if (o >= 0 && mbc[k] == 0) begin
        mop[k] = o;
      end else if (c == 9'h05A && mbc[k] >= 1) begin
        mst[k] = 2; mgo[k] = 1;
      end
    end else begin
      if (d >= 0) begin
        ma[k] = d; mac[k] = 1; mb[k] = 0; mbc[k] = 0; mop[k] = 0; mst[k] = 0;
      end
    end
  endtask

  function automatic logic [7:0] mfield(input int v, input int cnt);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    if (cnt == 0) return 8'hFF;
    if (cnt == 1) return {4'hF, o};
    return {t, o};
  endfunction

  function automatic logic [15:0] mdisp(input int k);
    if (mst[k] == 0) return {8'hFF, mfield(ma[k], mac[k])};
    return {mfield(ma[k], mac[k]), mfield(mb[k], mbc[k])};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_dut(input int k, input string tag);
    logic [6:0]  a, b;
    logic [1:0]  op, st;
    logic        go;
    logic [15:0] dp;
    if (k == 0) begin
      a = bus0.operand_a; b = bus0.operand_b; op = bus0.opcode;
      go = bus0.calc_go; st = bus0.entry_state; dp = bus0.disp;
    end else begin
      a = bus1.operand_a; b = bus1.operand_b; op = bus1.opcode;
      go = bus1.calc_go; st = bus1.entry_state; dp = bus1.disp;
    end
    chk($sformatf("%s k%0d operand_a", tag, k), 32'(a), ma[k]);
    chk($sformatf("%s k%0d operand_b", tag, k), 32'(b), mb[k]);
    chk($sformatf("%s k%0d opcode", tag, k), 32'(op), mop[k]);
    chk($sformatf("%s k%0d calc_go", tag, k), 32'(go), mgo[k]);
    chk($sformatf("%s k%0d entry_state", tag, k), 32'(st), mst[k]);
    chk($sformatf("%s k%0d disp", tag, k), 32'(dp), 32'(mdisp(k)));
  endtask

  task automatic check_both(input string tag);
    check_dut(0, tag);
    check_dut(1, tag);
  endtask

  // Drive one key_valid strobe at posedge+1, return at the next posedge+1
  task automatic strobe(input logic [8:0] code, input bit down);
    bus1.last_change = code;
    bus1.key_down[code] = down;
    bus1.key_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.key_valid = 1'b0;
    bus1.key_down[code] = 1'b0;
    for (int k = 0; k < 2; k++) model_step(k, code, down, 1'b1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) model_step(k, 9'h0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [8:0]  code;
    bit          down;
    int          a;
    int          b;
    int          op;
    bit          go;
    int          st;
    logic [15:0] disp;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [8:0] code;
    bit         down;
    int         sel;
    logic       prev_go;

    vecs[0]  = '{9'h016, 1'b1, 1,  0, 0, 1'b0, 0, 16'hFFF1};
    vecs[1]  = '{9'h01E, 1'b1, 12, 0, 0, 1'b0, 0, 16'hFF12};
    vecs[2]  = '{9'h026, 1'b1, 12, 0, 0, 1'b0, 0, 16'hFF12};  // third digit dropped
    vecs[3]  = '{9'h016, 1'b0, 12, 0, 0, 1'b0, 0, 16'hFF12};  // release strobe
    vecs[4]  = '{9'h079, 1'b1, 12, 0, 0, 1'b0, 1, 16'h12FF};
    vecs[5]  = '{9'h05A, 1'b1, 12, 0, 0, 1'b0, 1, 16'h12FF};  // Enter with no B digit
    vecs[6]  = '{9'h07B, 1'b1, 12, 0, 1, 1'b0, 1, 16'h12FF};  // operator replaced
    vecs[7]  = '{9'h079, 1'b1, 12, 0, 0, 1'b0, 1, 16'h12FF};
    vecs[8]  = '{9'h026, 1'b1, 12, 3, 0, 1'b0, 1, 16'h12F3};
    vecs[9]  = '{9'h07C, 1'b1, 12, 3, 0, 1'b0, 1, 16'h12F3};  // operator after B digit
    vecs[10] = '{9'h05A, 1'b1, 12, 3, 0, 1'b1, 2, 16'h12F3};
    vecs[11] = '{9'h07C, 1'b1, 12, 3, 0, 1'b0, 2, 16'h12F3};  // go dropped, op ignored
    vecs[12] = '{9'h03D, 1'b1, 7,  0, 0, 1'b0, 0, 16'hFFF7};
    vecs[13] = '{9'h076, 1'b1, 0,  0, 0, 1'b0, 0, 16'hFFFF};
    vecs[14] = '{9'h07B, 1'b1, 0,  0, 0, 1'b0, 0, 16'hFFFF};  // operator with no A

    bus1.key_down    = '0;
    bus1.last_change = 9'h0;
    bus1.key_valid   = 1'b0;
    model_reset();

    // Presses while reset is held are ignored
    @(posedge clk);
    #1;
    strobe(9'h016, 1'b1);
    model_reset();
    check_both("reset");
    rst = 1'b0;
    idle();
    check_both("post_reset");

    for (int i = 0; i < 15; i++) begin
      strobe(vecs[i].code, vecs[i].down);
      chk($sformatf("vec%0d operand_a", i), 32'(bus1.operand_a), vecs[i].a);
      chk($sformatf("vec%0d operand_b", i), 32'(bus1.operand_b), vecs[i].b);
      chk($sformatf("vec%0d opcode", i), 32'(bus1.opcode), vecs[i].op);
      chk($sformatf("vec%0d calc_go", i), 32'(bus1.calc_go), 32'(vecs[i].go));
      chk($sformatf("vec%0d entry_state", i), 32'(bus1.entry_state), vecs[i].st);
      chk($sformatf("vec%0d disp", i), 32'(bus1.disp), 32'(vecs[i].disp));
    end

    // ESC mid-B_ENTRY
    strobe(9'h016, 1'b1);
    strobe(9'h079, 1'b1);
    strobe(9'h01E, 1'b1);
    check_both("pre_esc");
    strobe(9'h076, 1'b1);
    check_both("esc_mid_b");
    chk("esc disp", 32'(bus1.disp), 32'hFFFF);

    // Asynchronous reset mid-B_ENTRY, sampled before any clock edge
    strobe(9'h016, 1'b1);
    strobe(9'h079, 1'b1);
    strobe(9'h01E, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async entry_state", 32'(bus1.entry_state), 32'd0);
    chk("async operand_a", 32'(bus1.operand_a), 32'd0);
    chk("async operand_b", 32'(bus1.operand_b), 32'd0);
    chk("async disp", 32'(bus1.disp), 32'hFFFF);
    #2 rst = 1'b0;
    model_reset();
    idle();
    check_both("after_async");

    // Keypad code: accepted only by the KEYPAD_EN=1 copy
    strobe(9'h06C, 1'b1);
    check_both("keypad");
    chk("nokp keypad operand_a", 32'(bus0.operand_a), 32'd0);
    chk("nokp keypad disp", 32'(bus0.disp), 32'hFFFF);
    chk("kp keypad disp", 32'(bus1.disp), 32'hFFF7);
    strobe(9'h076, 1'b1);

    // Random key events against the model
    prev_go = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 8) begin
        bus1.last_change = 9'($urandom_range(0, 511));
        idle();
      end else begin
        if (sel < 38)      code = 9'(top_codes[$urandom_range(0, 9)]);
        else if (sel < 58) code = 9'(pad_codes[$urandom_range(0, 9)]);
        else if (sel < 72) code = 9'(9'h079 + 9'($urandom_range(0, 3)));
        else if (sel < 85) code = 9'h05A;
        else if (sel < 88) code = 9'h076;
        else               code = 9'($urandom_range(0, 511));
        down = ($urandom_range(0, 3) != 0);
        strobe(code, down);
      end
      check_both("rand");
      chk("rand go_twice", 32'(prev_go & bus1.calc_go), 32'd0);
      prev_go = bus1.calc_go;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
